// File: rtl/sqrt_result_collector_if.sv
// rtl/sqrt_result_collector_if.sv - tag allocation, lane return and ordered result bundle
// The collector takes the slave side; the distributor, workers and consumer together drive the master side.
interface sqrt_result_collector_if #(
  parameter int N     = 5,
  parameter int W     = 32,
  parameter int DEPTH = 8
);
  localparam int TAG_W = $clog2(DEPTH);

  logic               alloc_vld;
  logic               alloc_rdy;
  logic [TAG_W-1:0]   alloc_tag;
  logic [N-1:0]       lane_vld;
  logic [N*TAG_W-1:0] lane_tag;
  logic [N*W-1:0]     lane_res;
  logic               res_vld;
  logic [W-1:0]       res;
  logic               res_rdy;
  logic [TAG_W:0]     occupancy;
  logic               err;

  modport slave (
    input  alloc_vld, lane_vld, lane_tag, lane_res, res_rdy,
    output alloc_rdy, alloc_tag, res_vld, res, occupancy, err
  );

  modport master (
    output alloc_vld, lane_vld, lane_tag, lane_res, res_rdy,
    input  alloc_rdy, alloc_tag, res_vld, res, occupancy, err
  );
endinterface

// File: rtl/sqrt_result_collector.sv
// rtl/sqrt_result_collector.sv - reorder buffer returning out-of-order worker results in tag order
// Slots cycle FREE -> PENDING (allocated) -> DONE (result captured) -> FREE (popped).
module sqrt_result_collector #(
  parameter int N     = 5,
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  sqrt_result_collector_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_DONE    = 2'd2
  } slot_e;

  slot_e            state_q [DEPTH];
  slot_e            state_d [DEPTH];
  logic [W-1:0]     data_q  [DEPTH];
  logic [W-1:0]     data_d  [DEPTH];
  logic [TAG_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             err_q, err_d;

  logic             alloc_rdy, alloc_fire, head_done, pop, lane_err;
  logic [DEPTH-1:0] claimed;
  logic [TAG_W-1:0] tag;

  always_comb begin
    alloc_rdy  = (count_q != (TAG_W+1)'(DEPTH));
    alloc_fire = bus.alloc_vld && alloc_rdy;
    head_done  = (state_q[rd_ptr_q] == SLOT_DONE);
    pop        = head_done && bus.res_rdy;
    state_d    = state_q;
    data_d     = data_q;
    claimed    = '0;
    lane_err   = 1'b0;
    tag        = '0;

    // Lanes are scanned from index 0 so the lowest lane claims a duplicated tag first.
    for (int i = 0; i < N; i++) begin
      tag = bus.lane_tag[i*TAG_W +: TAG_W];
      if (bus.lane_vld[i]) begin
        if (claimed[tag]) begin
          lane_err = 1'b1;
        end else begin
          claimed[tag] = 1'b1;
          if (state_q[tag] == SLOT_PENDING) begin
            state_d[tag] = SLOT_DONE;
            data_d[tag]  = bus.lane_res[i*W +: W];
          end else begin
            lane_err = 1'b1;
          end
        end
      end
    end

    // Alloc targets a FREE slot and pop a DONE slot, so neither collides with a completion.
    if (alloc_fire) state_d[wr_ptr_q] = SLOT_PENDING;
    if (pop)        state_d[rd_ptr_q] = SLOT_FREE;

    wr_ptr_d = alloc_fire ? wr_ptr_q + TAG_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + TAG_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (alloc_fire && !pop)      count_d = count_q + (TAG_W+1)'(1);
    else if (!alloc_fire && pop) count_d = count_q - (TAG_W+1)'(1);

    err_d = err_q | lane_err | (bus.alloc_vld & ~alloc_rdy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        state_q[s] <= SLOT_FREE;
        data_q[s]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign bus.alloc_rdy = alloc_rdy;
  assign bus.alloc_tag = wr_ptr_q;
  assign bus.res_vld   = head_done;
  assign bus.res       = head_done ? data_q[rd_ptr_q] : '0;
  assign bus.occupancy = count_q;
  assign bus.err       = err_q;
endmodule

// File: doc/sqrt_result_collector.md
Name: sqrt_result_collector

Overview:
- Return-path companion to the task distributor. Worker units finish out of order, and this block puts their results back in issue order.
- The distributor takes a tag from this block for every task it issues. Each worker lane hands its result back with that tag.
- Results are held in a reorder buffer and emitted strictly in tag order over a valid/ready output.
- The block sits between the worker array and the downstream consumer of the formula results.

Parameters:
N, 5, number of worker lanes returning results
W, 32, result data width
DEPTH, 8, reorder buffer slots; must be a power of 2 and >= 2
TAG_W, $clog2(DEPTH), tag width (derived)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
alloc_vld  input  1  distributor claims the current alloc_tag for a newly issued task
alloc_rdy  output  1  a slot is free (occupancy < DEPTH)
alloc_tag  output  TAG_W  tag to attach to the task issued this cycle (write pointer)
lane_vld  input  N  per-lane result valid, one-cycle pulse
lane_tag  input  N*TAG_W  per-lane tag, packed; lane i occupies bits [i*TAG_W +: TAG_W]
lane_res  input  N*W  per-lane result, packed; lane i occupies bits [i*W +: W]
res_vld  output  1  head-of-order result available
res  output  W  head result; forced to 0 when res_vld=0
res_rdy  input  1  downstream accepts res this cycle
occupancy  output  TAG_W+1  allocated, not-yet-popped slots
err  output  1  sticky protocol-violation flag

Behaviour:
- Each slot has state FREE, PENDING or DONE, plus a W-bit data register. The block keeps wr_ptr, rd_ptr and a count.
- Reset (synchronous):
  - all slots go FREE; wr_ptr, rd_ptr and count go to 0; err goes to 0.
  - Outputs after reset: alloc_rdy=1, alloc_tag=0, res_vld=0, res=0, occupancy=0.
  - Reset mid-operation discards all contents. lane_vld and alloc_vld are ignored in the reset cycle.
- Allocate: when alloc_vld && alloc_rdy, slot[wr_ptr] goes FREE->PENDING and wr_ptr increments, wrapping modulo DEPTH.
  - alloc_tag is valid combinationally in the same cycle.
  - alloc_vld while alloc_rdy=0 is ignored and sets err.
- Complete: for each lane i with lane_vld[i], if slot[tag_i] is PENDING, it captures lane_res[i] and goes PENDING->DONE.
  - Any number of lanes with distinct tags may complete in the same cycle; all are accepted.
  - A tag whose slot is FREE or DONE is dropped and sets err.
  - If several lanes carry the same tag in one cycle, the lowest lane index wins and err is set.
- Output:
  - res_vld = (slot[rd_ptr]==DONE), driven combinationally from registered state. res = data[rd_ptr].
  - Latency from a lane completion to res_vld is 1 cycle, provided that slot is at the head.
  - res_vld && res_rdy: slot[rd_ptr] goes to FREE and rd_ptr increments, wrapping.
  - While res_vld=1 and res_rdy=0, res and res_vld hold stable.
- Count: count_next = count + (alloc accepted) - (pop).
  - alloc_rdy uses the current count. A pop does not free a slot for allocation in the same cycle (no bypass).
  - Alloc and pop may both occur in the same cycle when not full; count is then unchanged.
- Same-cycle interactions:
  - A completion to the head slot and a pop cannot coincide, because the head must already be DONE to pop.
  - An allocate to a slot and a completion to the same slot in the same cycle counts as an error: the slot was FREE at the start of the cycle.
- Full: count==DEPTH gives alloc_rdy=0.
- Empty: count==0 gives res_vld=0.
- Pointer wrap-around must be seamless across many DEPTH cycles.
- err is cleared only by rst.

Test Plan:
- In-order return:
  - Stimulus: allocate tags 0,1,2. Lanes 0,1,2 return 0xA,0xB,0xC with tags 0,1,2 on consecutive cycles. res_rdy=1.
  - Response: res shows 0xA,0xB,0xC in that order, each 1 cycle after its completion; occupancy returns to 0; err=0.
- Out-of-order return:
  - Stimulus: allocate tags 0..3. Complete tag 3 (0x33), then 1 (0x11), then 2 (0x22), then 0 (0x00).
  - Response: res_vld stays 0 until tag 0 completes. Then 0x00,0x11,0x22,0x33 appear on 4 consecutive cycles.
- Simultaneous completions:
  - Stimulus: allocate 5 tags. All 5 lanes pulse in one cycle with tags 4,3,2,1,0 and data 0x50..0x54.
  - Response: 5 results stream out in tag order 0..4 with no gaps; err=0.
- Full and backpressure:
  - Stimulus: allocate 8 and hold res_rdy=0.
  - Response: alloc_rdy=0 and occupancy=8; an extra alloc_vld sets err. Complete all 8: res held stable.
  - Then raise res_rdy: 8 pops. alloc_rdy=1 only on the cycle after the first pop.
- Wrap-around and errors:
  - Stimulus: run 20 alloc/complete/pop rounds so pointers wrap twice; data must match.
  - Then send a lane result with a FREE tag: err=1 and occupancy unchanged.
- Reset mid-operation:
  - Stimulus: 3 PENDING slots and 1 DONE slot, then pulse rst for 1 cycle.
  - Response: next cycle res_vld=0, occupancy=0, alloc_tag=0, err=0.
